// File: rtl/display_source_ctrl.sv
// display_source_ctrl
//   Upstream feeder for the four-digit seven-segment monitor. Selects the
//   16-bit word shown on the display from one of three sources:
//     PORT   : 16-bit word assembled from two 8-bit CPU port writes
//              (high byte staged first, low byte write commits)
//     DEBUG  : live 16-bit debug word (e.g. {PC, IR})
//     FREEZE : snapshot of the PORT word taken when FREEZE is entered
//   A debounced pushbutton cycles PORT -> DEBUG -> FREEZE -> PORT.
//
// Ports
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     CPU port write strobe, one cycle per write
//   wr_addr   0 = low byte (commit), 1 = high byte (stage)
//   wr_data   CPU write data
//   dbg_word  debug source word, sampled every cycle
//   btn       raw asynchronous pushbutton, active-high
//   dataout   registered word to the seven-segment monitor
//   mode      current source: 0 PORT, 1 DEBUG, 2 FREEZE
//   commit    one-cycle registered pulse after a low-byte write
module display_source_ctrl #(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned CNT_W      = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [15:0] dbg_word,
  input  logic        btn,
  output logic [15:0] dataout,
  output logic [1:0]  mode,
  output logic        commit
);

  localparam logic [1:0] PORT   = 2'd0;
  localparam logic [1:0] DEBUG  = 2'd1;
  localparam logic [1:0] FREEZE = 2'd2;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  // CPU port state
  logic [7:0]  hi_stage;
  logic [15:0] port_reg;
  logic [15:0] snapshot;

  // Button path state
  logic             sync1;
  logic             s;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press_acc;

  logic [1:0]  mode_nxt;
  logic [15:0] dout_nxt;

  // ---------------------------------------------------------------------------
  // CPU port: high byte is staged and kept; low byte write commits the word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_stage <= '0;
      port_reg <= '0;
      commit   <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (wr_en) begin
        if (wr_addr) begin
          hi_stage <= wr_data;
        end else begin
          port_reg <= {hi_stage, wr_data};
          commit   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchronizer and debouncer. The counter only runs while the
  // synchronized level differs from the accepted level; any agreeing sample
  // restarts it, so pulses shorter than DEB_CYCLES are rejected.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Accepted press is the cycle in which stable is about to go 0 -> 1; the
  // mode advances on that same edge.
  always_comb begin
    press_acc = 1'b0;
    if ((s != stable) && (cnt == DEB_LAST) && s) begin
      press_acc = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM. Encoding 3 is unreachable and behaves like PORT.
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_nxt = mode;
    if (press_acc) begin
      case (mode)
        DEBUG:   mode_nxt = FREEZE;
        FREEZE:  mode_nxt = PORT;
        default: mode_nxt = DEBUG;
      endcase
    end
  end

  // Snapshot captures port_reg as it was before the edge, so a commit landing
  // on the same edge as entry into FREEZE is not included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= PORT;
      snapshot <= '0;
    end else begin
      mode <= mode_nxt;
      if (press_acc && (mode == DEBUG)) begin
        snapshot <= port_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output select from pre-edge register values; dataout lags one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    dout_nxt = port_reg;
    case (mode)
      DEBUG:   dout_nxt = dbg_word;
      FREEZE:  dout_nxt = snapshot;
      default: dout_nxt = port_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout <= '0;
    end else begin
      dataout <= dout_nxt;
    end
  end

endmodule
